// File: rtl/rv32_fetch_decode_execute_if.sv
`default_nettype none
// ============================================================================
// rv32_fetch_decode_execute_if : fetch, decode and execute bus bundle. Rev 1.0
// ============================================================================
interface rv32_fetch_decode_execute_if;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] fetch_pc;
   logic        ifu_ready_to_mem;
   logic        commit;
   logic        stage_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] csr_addr;
   logic        is_load;
   logic        is_store;
   logic        is_ecall;
   logic        inst_invalid;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] csr_rdata;
   logic [31:0] mepc;
   logic [31:0] mtvec;
   logic [31:0] result;
   logic [31:0] next_pc;
   logic        reg_write_en;
   logic        csr_we;
   logic [31:0] csr_wdata;

   // Core side: memory, register file, CSR file and commit logic.
   modport master (
      output imem_rdata, imem_rvalid, fetch_pc, commit,
             rs1_data, rs2_data, csr_rdata, mepc, mtvec,
      input  ifu_ready_to_mem, stage_valid, inst, pc,
             rs1_addr, rs2_addr, rd_addr, opcode, funct3, funct7, csr_addr,
             is_load, is_store, is_ecall, inst_invalid,
             result, next_pc, reg_write_en, csr_we, csr_wdata
   );

   // Front-end side.
   modport slave (
      input  imem_rdata, imem_rvalid, fetch_pc, commit,
             rs1_data, rs2_data, csr_rdata, mepc, mtvec,
      output ifu_ready_to_mem, stage_valid, inst, pc,
             rs1_addr, rs2_addr, rd_addr, opcode, funct3, funct7, csr_addr,
             is_load, is_store, is_ecall, inst_invalid,
             result, next_pc, reg_write_en, csr_we, csr_wdata
   );
endinterface
`default_nettype wire

// File: rtl/rv32_fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// rv32_fetch_decode_execute : RV32I holding stage, decoder and execute. Rev 1.0
// ============================================================================
module rv32_fetch_decode_execute #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   rv32_fetch_decode_execute_if.slave   bus
);
   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0]  F7_ZERO    = 7'b0000000;
   localparam logic [6:0]  F7_ALT     = 7'b0100000;
   localparam logic [2:0]  F3_CSRRW   = 3'b001;
   localparam logic [2:0]  F3_CSRRS   = 3'b010;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   logic        held_valid;
   logic [31:0] held_inst;
   logic [31:0] held_pc;

   // Accept only when empty and retire only when full, so the two never overlap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         held_valid <= 1'b0;
         held_inst  <= 32'd0;
         held_pc    <= RESET_PC;
      end else if (held_valid) begin
         if (bus.commit) begin
            held_valid <= 1'b0;
         end
      end else if (bus.imem_rvalid) begin
         held_valid <= 1'b1;
         held_inst  <= bus.imem_rdata;
         held_pc    <= bus.fetch_pc;
      end
   end

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd_addr;
   logic [4:0]  rs1_addr;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign opcode   = held_inst[6:0];
   assign funct3   = held_inst[14:12];
   assign funct7   = held_inst[31:25];
   assign rd_addr  = held_inst[11:7];
   assign rs1_addr = held_inst[19:15];
   assign imm_i    = {{20{held_inst[31]}}, held_inst[31:20]};
   assign imm_s    = {{20{held_inst[31]}}, held_inst[31:25], held_inst[11:7]};
   assign imm_b    = {{19{held_inst[31]}}, held_inst[31], held_inst[7],
                      held_inst[30:25], held_inst[11:8], 1'b0};
   assign imm_u    = {held_inst[31:12], 12'd0};
   assign imm_j    = {{11{held_inst[31]}}, held_inst[31], held_inst[19:12],
                      held_inst[20], held_inst[30:21], 1'b0};

   logic bad_encoding;

   always_comb begin
      bad_encoding = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: bad_encoding = 1'b0;
         OPC_JALR:   bad_encoding = (funct3 != 3'b000);
         OPC_BRANCH: bad_encoding = (funct3 == 3'b010) || (funct3 == 3'b011);
         OPC_LOAD:   bad_encoding = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                    (funct3 == 3'b111);
         OPC_STORE:  bad_encoding = (funct3 > 3'b010);
         OPC_OPIMM: begin
            if (funct3 == 3'b001) begin
               bad_encoding = (funct7 != F7_ZERO);
            end else if (funct3 == 3'b101) begin
               bad_encoding = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
         end
         OPC_OP: bad_encoding = !((funct7 == F7_ZERO) ||
                                  ((funct7 == F7_ALT) &&
                                   ((funct3 == 3'b000) || (funct3 == 3'b101))));
         OPC_SYSTEM: bad_encoding = !((held_inst == INST_ECALL) ||
                                      (held_inst == INST_EBREAK) ||
                                      (held_inst == INST_MRET) ||
                                      (funct3 == F3_CSRRW) || (funct3 == F3_CSRRS));
         default: bad_encoding = 1'b1;
      endcase
   end

   // Arithmetic right shift goes through $unsigned() so the signed operand
   // is not reinterpreted as unsigned by the surrounding context.
   function automatic logic [31:0] alu(input logic [2:0]  f3,
                                       input logic        alt,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f3)
         3'b000:  alu = alt ? (a - b) : (a + b);
         3'b001:  alu = a << sh;
         3'b010:  alu = {31'd0, ($signed(a) < $signed(b))};
         3'b011:  alu = {31'd0, (a < b)};
         3'b100:  alu = a ^ b;
         3'b101: begin
            if (alt) alu = $unsigned($signed(a) >>> sh);
            else     alu = a >> sh;
         end
         3'b110:  alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   logic [31:0] pc_plus4;
   logic [31:0] exe_result;
   logic [31:0] exe_next_pc;
   logic [31:0] exe_csr_wdata;
   logic        csr_request;
   logic        writes_gpr;
   logic        branch_taken;

   assign pc_plus4 = held_pc + 32'd4;

   always_comb begin
      case (funct3)
         3'b000:  branch_taken = (bus.rs1_data == bus.rs2_data);
         3'b001:  branch_taken = (bus.rs1_data != bus.rs2_data);
         3'b100:  branch_taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
         3'b101:  branch_taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         3'b110:  branch_taken = (bus.rs1_data <  bus.rs2_data);
         3'b111:  branch_taken = (bus.rs1_data >= bus.rs2_data);
         default: branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      exe_result    = 32'd0;
      exe_next_pc   = pc_plus4;
      exe_csr_wdata = 32'd0;
      csr_request   = 1'b0;
      writes_gpr    = 1'b0;
      case (opcode)
         OPC_LUI: begin
            exe_result = imm_u;
            writes_gpr = 1'b1;
         end
         OPC_AUIPC: begin
            exe_result = held_pc + imm_u;
            writes_gpr = 1'b1;
         end
         OPC_JAL: begin
            exe_result  = pc_plus4;
            exe_next_pc = held_pc + imm_j;
            writes_gpr  = 1'b1;
         end
         OPC_JALR: begin
            exe_result  = pc_plus4;
            exe_next_pc = (bus.rs1_data + imm_i) & ~32'd1;
            writes_gpr  = 1'b1;
         end
         OPC_BRANCH: begin
            if (branch_taken) exe_next_pc = held_pc + imm_b;
         end
         OPC_LOAD: begin
            exe_result = bus.rs1_data + imm_i;
            writes_gpr = 1'b1;
         end
         OPC_STORE: exe_result = bus.rs1_data + imm_s;
         OPC_OPIMM: begin
            exe_result = alu(funct3, (funct3 == 3'b101) && funct7[5],
                             bus.rs1_data, imm_i);
            writes_gpr = 1'b1;
         end
         OPC_OP: begin
            exe_result = alu(funct3, funct7[5], bus.rs1_data, bus.rs2_data);
            writes_gpr = 1'b1;
         end
         OPC_SYSTEM: begin
            if (funct3 == F3_CSRRW) begin
               exe_result    = bus.csr_rdata;
               exe_csr_wdata = bus.rs1_data;
               csr_request   = 1'b1;
               writes_gpr    = 1'b1;
            end else if (funct3 == F3_CSRRS) begin
               exe_result    = bus.csr_rdata;
               exe_csr_wdata = bus.csr_rdata | bus.rs1_data;
               csr_request   = (rs1_addr != 5'd0);
               writes_gpr    = 1'b1;
            end else if (held_inst == INST_ECALL) begin
               exe_next_pc = bus.mtvec;
            end else if (held_inst == INST_MRET) begin
               exe_next_pc = bus.mepc;
            end
         end
         default: exe_result = 32'd0;
      endcase
      if (bad_encoding) exe_next_pc = pc_plus4;
   end

   assign bus.ifu_ready_to_mem = !held_valid;
   assign bus.stage_valid      = held_valid;
   assign bus.inst             = held_inst;
   assign bus.pc               = held_pc;
   assign bus.rs1_addr         = rs1_addr;
   assign bus.rs2_addr         = held_inst[24:20];
   assign bus.rd_addr          = rd_addr;
   assign bus.opcode           = opcode;
   assign bus.funct3           = funct3;
   assign bus.funct7           = funct7;
   assign bus.csr_addr         = held_inst[31:20];
   assign bus.is_load          = (opcode == OPC_LOAD);
   assign bus.is_store         = (opcode == OPC_STORE);
   assign bus.is_ecall         = (held_inst == INST_ECALL);
   assign bus.inst_invalid     = held_valid && bad_encoding;
   assign bus.result           = exe_result;
   assign bus.next_pc          = exe_next_pc;
   assign bus.reg_write_en     = held_valid && !bad_encoding && (rd_addr != 5'd0) && writes_gpr;
   assign bus.csr_we           = held_valid && !bad_encoding && csr_request;
   assign bus.csr_wdata        = exe_csr_wdata;
endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// tb_rv32_fetch_decode_execute : directed scoreboard bench for the RV32I front end. Rev 1.0
// ============================================================================
module tb_rv32_fetch_decode_execute;
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   rv32_fetch_decode_execute_if bus ();

   rv32_fetch_decode_execute #(.RESET_PC(32'h8000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endfunction

   task automatic sb_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // Present one word for a single cycle once the stage can take it.
   task automatic fetch(input logic [31:0] word, input logic [31:0] addr);
      int n;
      n = 0;
      while (bus.ifu_ready_to_mem !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      sb_push("fetch_ready", 32'd1);
      sb_check(32'(bus.ifu_ready_to_mem));
      bus.imem_rdata  = word;
      bus.fetch_pc    = addr;
      bus.imem_rvalid = 1'b1;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
   endtask

   task automatic retire();
      bus.commit = 1'b1;
      @(negedge clk);
      bus.commit = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "time limit reached");
   end

   initial begin
      bus.imem_rdata  = 32'd0;
      bus.imem_rvalid = 1'b0;
      bus.fetch_pc    = 32'd0;
      bus.commit      = 1'b0;
      bus.rs1_data    = 32'd0;
      bus.rs2_data    = 32'd0;
      bus.csr_rdata   = 32'd0;
      bus.mepc        = 32'd0;
      bus.mtvec       = 32'd0;
      repeat (3) @(negedge clk);

      sb_push("rst_valid", 32'd0);
      sb_push("rst_pc", 32'h8000_0000);
      sb_push("rst_inst", 32'd0);
      sb_push("rst_ready", 32'd1);
      sb_push("rst_invalid_gated", 32'd0);
      sb_check(32'(bus.stage_valid));
      sb_check(bus.pc);
      sb_check(bus.inst);
      sb_check(32'(bus.ifu_ready_to_mem));
      sb_check(32'(bus.inst_invalid));
      rst = 1'b1;
      @(negedge clk);

      // addi x1,x0,5
      bus.rs1_data = 32'd0;
      fetch(32'h0050_0093, 32'h8000_0000);
      sb_push("addi_valid", 32'd1);
      sb_push("addi_ready", 32'd0);
      sb_push("addi_result", 32'd5);
      sb_push("addi_rd", 32'd1);
      sb_push("addi_we", 32'd1);
      sb_push("addi_next_pc", 32'h8000_0004);
      sb_check(32'(bus.stage_valid));
      sb_check(32'(bus.ifu_ready_to_mem));
      sb_check(bus.result);
      sb_check(32'(bus.rd_addr));
      sb_check(32'(bus.reg_write_en));
      sb_check(bus.next_pc);

      // A word offered while full is dropped.
      bus.imem_rdata  = 32'hFFFF_FFFF;
      bus.fetch_pc    = 32'h8000_0F00;
      bus.imem_rvalid = 1'b1;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      sb_push("drop_inst", 32'h0050_0093);
      sb_push("drop_pc", 32'h8000_0000);
      sb_check(bus.inst);
      sb_check(bus.pc);

      retire();
      sb_push("commit_valid", 32'd0);
      sb_push("commit_ready", 32'd1);
      sb_push("commit_inst_hold", 32'h0050_0093);
      sb_check(32'(bus.stage_valid));
      sb_check(32'(bus.ifu_ready_to_mem));
      sb_check(bus.inst);

      // jal x1,+8
      fetch(32'h0080_00EF, 32'h8000_0010);
      sb_push("jal_result", 32'h8000_0014);
      sb_push("jal_next_pc", 32'h8000_0018);
      sb_push("jal_rd", 32'd1);
      sb_push("jal_we", 32'd1);
      sb_check(bus.result);
      sb_check(bus.next_pc);
      sb_check(32'(bus.rd_addr));
      sb_check(32'(bus.reg_write_en));
      retire();

      // bne x1,x2,+8 not taken, then taken
      bus.rs1_data = 32'd3;
      bus.rs2_data = 32'd3;
      fetch(32'h0020_9463, 32'h8000_0020);
      sb_push("bne_nt_next_pc", 32'h8000_0024);
      sb_push("bne_we", 32'd0);
      sb_push("bne_rs1_addr", 32'd1);
      sb_push("bne_rs2_addr", 32'd2);
      sb_check(bus.next_pc);
      sb_check(32'(bus.reg_write_en));
      sb_check(32'(bus.rs1_addr));
      sb_check(32'(bus.rs2_addr));
      bus.rs2_data = 32'd4;
      #1;
      sb_push("bne_t_next_pc", 32'h8000_0028);
      sb_check(bus.next_pc);
      retire();

      // ecall, mret, ebreak
      bus.mtvec = 32'h8000_0100;
      bus.mepc  = 32'h8000_0040;
      fetch(32'h0000_0073, 32'h8000_0030);
      sb_push("ecall_flag", 32'd1);
      sb_push("ecall_next_pc", 32'h8000_0100);
      sb_push("ecall_csr_we", 32'd0);
      sb_push("ecall_we", 32'd0);
      sb_check(32'(bus.is_ecall));
      sb_check(bus.next_pc);
      sb_check(32'(bus.csr_we));
      sb_check(32'(bus.reg_write_en));
      retire();
      fetch(32'h3020_0073, 32'h8000_0034);
      sb_push("mret_next_pc", 32'h8000_0040);
      sb_push("mret_ecall_flag", 32'd0);
      sb_push("mret_invalid", 32'd0);
      sb_check(bus.next_pc);
      sb_check(32'(bus.is_ecall));
      sb_check(32'(bus.inst_invalid));
      retire();
      fetch(32'h0010_0073, 32'h8000_0038);
      sb_push("ebreak_next_pc", 32'h8000_003C);
      sb_push("ebreak_invalid", 32'd0);
      sb_check(bus.next_pc);
      sb_check(32'(bus.inst_invalid));
      retire();

      // csrrs x5,mtvec,x0 / csrrw x5,mtvec,x1 / csrrs x5,mtvec,x1
      bus.csr_rdata = 32'h0000_1234;
      bus.rs1_data  = 32'h0000_00AA;
      fetch(32'h3050_22F3, 32'h8000_0040);
      sb_push("csrrs0_result", 32'h0000_1234);
      sb_push("csrrs0_csr_we", 32'd0);
      sb_push("csrrs0_we", 32'd1);
      sb_push("csrrs0_csr_addr", 32'h0000_0305);
      sb_push("csrrs0_rd", 32'd5);
      sb_check(bus.result);
      sb_check(32'(bus.csr_we));
      sb_check(32'(bus.reg_write_en));
      sb_check(32'(bus.csr_addr));
      sb_check(32'(bus.rd_addr));
      retire();
      fetch(32'h3050_92F3, 32'h8000_0044);
      sb_push("csrrw_csr_we", 32'd1);
      sb_push("csrrw_wdata", 32'h0000_00AA);
      sb_push("csrrw_result", 32'h0000_1234);
      sb_check(32'(bus.csr_we));
      sb_check(bus.csr_wdata);
      sb_check(bus.result);
      retire();
      fetch(32'h3050_A2F3, 32'h8000_0048);
      sb_push("csrrs1_csr_we", 32'd1);
      sb_push("csrrs1_wdata", 32'h0000_12BE);
      sb_check(32'(bus.csr_we));
      sb_check(bus.csr_wdata);
      retire();

      // undefined word
      fetch(32'hFFFF_FFFF, 32'h8000_0050);
      sb_push("undef_invalid", 32'd1);
      sb_push("undef_we", 32'd0);
      sb_push("undef_next_pc", 32'h8000_0054);
      sb_push("undef_csr_we", 32'd0);
      sb_check(32'(bus.inst_invalid));
      sb_check(32'(bus.reg_write_en));
      sb_check(bus.next_pc);
      sb_check(32'(bus.csr_we));
      retire();

      // sub x3,x1,x2
      bus.rs1_data = 32'd5;
      bus.rs2_data = 32'd7;
      fetch(32'h4020_81B3, 32'h8000_0060);
      sb_push("sub_result", 32'hFFFF_FFFE);
      sb_push("sub_we", 32'd1);
      sb_check(bus.result);
      sb_check(32'(bus.reg_write_en));
      retire();

      // srai x3,x1,4
      bus.rs1_data = 32'h8000_0000;
      fetch(32'h4040_D193, 32'h8000_0064);
      sb_push("srai_result", 32'hF800_0000);
      sb_push("srai_invalid", 32'd0);
      sb_check(bus.result);
      sb_check(32'(bus.inst_invalid));
      retire();

      // lw x1,-4(x2)
      bus.rs1_data = 32'h0000_1000;
      fetch(32'hFFC1_2083, 32'h8000_0068);
      sb_push("lw_addr", 32'h0000_0FFC);
      sb_push("lw_is_load", 32'd1);
      sb_push("lw_we", 32'd1);
      sb_check(bus.result);
      sb_check(32'(bus.is_load));
      sb_check(32'(bus.reg_write_en));
      retire();

      // sw x2,8(x1)
      bus.rs1_data = 32'h0000_0100;
      fetch(32'h0020_A423, 32'h8000_006C);
      sb_push("sw_addr", 32'h0000_0108);
      sb_push("sw_is_store", 32'd1);
      sb_push("sw_we", 32'd0);
      sb_check(bus.result);
      sb_check(32'(bus.is_store));
      sb_check(32'(bus.reg_write_en));
      retire();

      // jalr x1,5(x2)
      bus.rs1_data = 32'h8000_0200;
      fetch(32'h0051_00E7, 32'h8000_0070);
      sb_push("jalr_result", 32'h8000_0074);
      sb_push("jalr_next_pc", 32'h8000_0204);
      sb_check(bus.result);
      sb_check(bus.next_pc);
      retire();

      // reset while an instruction is held
      fetch(32'h0050_0093, 32'h8000_0090);
      sb_push("held_pc", 32'h8000_0090);
      sb_check(bus.pc);
      rst = 1'b0;
      @(negedge clk);
      sb_push("rst2_valid", 32'd0);
      sb_push("rst2_pc", 32'h8000_0000);
      sb_push("rst2_inst", 32'd0);
      sb_check(32'(bus.stage_valid));
      sb_check(bus.pc);
      sb_check(bus.inst);
      rst = 1'b1;
      @(negedge clk);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
